// File: rtl/register_file_scoreboard.sv
// Purpose : architectural register file with write-to-read bypass and a pending-write scoreboard.
// Latency : reads are combinational; commits are stored at the next clock edge; pending bits appear the cycle after issue.
// Backpressure: issue_hold refuses a WAW issue to a pending register; decode retries until the register commits.
//
// Ports:
//   clock, reset_n                 - rising-edge clock, asynchronous active-low reset
//   pc                             - value returned for reads of the PC slot (index NR-2)
//   rd_index/rd_value/rd_hazard    - NREAD read ports: index in, data and RAW-hazard flag out
//   issue_valid/issue_register     - decode issues a writer of issue_register; issue_hold refuses it
//   flush                          - clears every pending bit, suppresses a same-cycle issue
//   wr_valid/wr_register/wr_value  - write-stage commit
//   flags_valid/flags              - dedicated update of bits 3:0 of the Flags slot (index NR-1)
module register_file_scoreboard #(
  parameter int NR    = 32,
  parameter int NREAD = 3,
  parameter int W     = 32
) (
  input  logic                        clock,
  input  logic                        reset_n,
  input  logic [W-1:0]                pc,
  input  logic [NREAD-1:0][4:0]       rd_index,
  output logic [NREAD-1:0][W-1:0]     rd_value,
  output logic [NREAD-1:0]            rd_hazard,
  input  logic                        issue_valid,
  input  logic [4:0]                  issue_register,
  output logic                        issue_hold,
  input  logic                        flush,
  input  logic                        wr_valid,
  input  logic [4:0]                  wr_register,
  input  logic [W-1:0]                wr_value,
  input  logic                        flags_valid,
  input  logic [3:0]                  flags
);

  localparam int             AW     = $clog2(NR);
  localparam logic [4:0]     PC_IDX = 5'(NR - 2);
  localparam logic [4:0]     FL_IDX = 5'(NR - 1);
  localparam logic [AW-1:0]  FL_A   = AW'(NR - 1);

  logic [NR-1:0][W-1:0] r_regs;
  logic [NR-1:0]        r_pending;

  // Indices are 5 bits wide; anything at or above NR does not exist.
  function automatic logic f_legal(input logic [4:0] idx);
    return ({1'b0, idx} < 6'(NR));
  endfunction

  logic          w_wr_legal;
  logic [AW-1:0] w_wr_addr;
  logic          w_wr_store;
  logic          w_iss_legal;
  logic [AW-1:0] w_iss_addr;
  logic          w_iss_byp;
  logic          w_iss_accept;

  assign w_wr_legal   = wr_valid && f_legal(wr_register);
  assign w_wr_addr    = wr_register[AW-1:0];
  // r0 and PC have no storage that may change.
  assign w_wr_store   = w_wr_legal && (wr_register != '0) && (wr_register != PC_IDX);

  assign w_iss_legal  = f_legal(issue_register);
  assign w_iss_addr   = issue_register[AW-1:0];
  // A commit to the same register this cycle resolves the WAW, so no hold.
  assign w_iss_byp    = w_wr_legal && (wr_register == issue_register);
  assign issue_hold   = issue_valid && w_iss_legal && r_pending[w_iss_addr] && !w_iss_byp && !flush;
  assign w_iss_accept = issue_valid && w_iss_legal && !issue_hold && !flush &&
                        (issue_register != '0) && (issue_register != PC_IDX);

  // Read ports: r0, then PC, then commit bypass, then storage; the flags
  // update overrides the low nibble of the Flags slot on top of all that.
  always_comb begin
    for (int i = 0; i < NREAD; i++) begin
      rd_value[i]  = '0;
      rd_hazard[i] = 1'b0;
      if (f_legal(rd_index[i])) begin
        if (rd_index[i] == PC_IDX) begin
          rd_value[i] = pc;
        end else if (rd_index[i] != '0) begin
          if (w_wr_legal && (wr_register == rd_index[i])) begin
            rd_value[i] = wr_value;
          end else begin
            rd_value[i] = r_regs[rd_index[i][AW-1:0]];
          end
          if (flags_valid && (rd_index[i] == FL_IDX)) begin
            rd_value[i][3:0] = flags;
          end
        end
        // Pending bits of r0 and PC are never set, so no extra masking here.
        rd_hazard[i] = r_pending[rd_index[i][AW-1:0]] &&
                       !(w_wr_legal && (wr_register == rd_index[i]));
      end
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_regs    <= '0;
      r_pending <= '0;
    end else begin
      if (w_wr_store) begin
        r_regs[w_wr_addr] <= wr_value;
      end
      // Issued after the full-word write so a simultaneous commit to Flags
      // keeps its upper bits and takes the low nibble from flags.
      if (flags_valid) begin
        r_regs[FL_A][3:0] <= flags;
      end
      if (flush) begin
        r_pending <= '0;
      end else begin
        if (w_wr_legal) begin
          r_pending[w_wr_addr] <= 1'b0;
        end
        // Set after clear: an issue and a commit to one register keep it pending.
        if (w_iss_accept) begin
          r_pending[w_iss_addr] <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_register_file_scoreboard.sv
module tb_register_file_scoreboard;

  logic              clock;
  logic              reset_n;
  logic [31:0]       pc;
  logic [2:0][4:0]   rd_index;
  logic [2:0][31:0]  rd_value;
  logic [2:0]        rd_hazard;
  logic              issue_valid;
  logic [4:0]        issue_register;
  logic              issue_hold;
  logic              flush;
  logic              wr_valid;
  logic [4:0]        wr_register;
  logic [31:0]       wr_value;
  logic              flags_valid;
  logic [3:0]        flags;

  register_file_scoreboard #(.NR(32), .NREAD(3), .W(32)) dut (
    .clock          (clock),
    .reset_n        (reset_n),
    .pc             (pc),
    .rd_index       (rd_index),
    .rd_value       (rd_value),
    .rd_hazard      (rd_hazard),
    .issue_valid    (issue_valid),
    .issue_register (issue_register),
    .issue_hold     (issue_hold),
    .flush          (flush),
    .wr_valid       (wr_valid),
    .wr_register    (wr_register),
    .wr_value       (wr_value),
    .flags_valid    (flags_valid),
    .flags          (flags)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    logic [31:0] v0;
    logic [31:0] v1;
    logic [31:0] v2;
    logic [2:0]  haz;
    logic        hold;
  } exp_t;

  exp_t  exp_q[$];
  string name_q[$];
  logic  chk_vld;
  int    n_tests;
  int    n_fail;
  exp_t  e;
  string nm;

  // Monitor: the DUT presents an observable result whenever chk_vld is high;
  // pop the expectation queued by the stimulus and compare.
  always @(negedge clock) begin
    if (chk_vld) begin
      n_tests++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL no_expectation: output observed with empty scoreboard");
      end else begin
        e  = exp_q.pop_front();
        nm = name_q.pop_front();
        if (rd_value[0] !== e.v0 || rd_value[1] !== e.v1 || rd_value[2] !== e.v2 ||
            rd_hazard !== e.haz || issue_hold !== e.hold) begin
          n_fail++;
          $display("FAIL %s: got val=%h/%h/%h haz=%b hold=%b, expected val=%h/%h/%h haz=%b hold=%b",
                   nm, rd_value[0], rd_value[1], rd_value[2], rd_hazard, issue_hold,
                   e.v0, e.v1, e.v2, e.haz, e.hold);
        end
      end
    end
  end

  task automatic idle();
    issue_valid    = 1'b0;
    issue_register = '0;
    flush          = 1'b0;
    wr_valid       = 1'b0;
    wr_register    = '0;
    wr_value       = '0;
    flags_valid    = 1'b0;
    flags          = '0;
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic rd(input logic [4:0] a, input logic [4:0] b, input logic [4:0] c);
    rd_index[0] = a;
    rd_index[1] = b;
    rd_index[2] = c;
  endtask

  task automatic wr(input logic [4:0] r, input logic [31:0] v);
    wr_valid    = 1'b1;
    wr_register = r;
    wr_value    = v;
  endtask

  task automatic iss(input logic [4:0] r);
    issue_valid    = 1'b1;
    issue_register = r;
  endtask

  task automatic fl(input logic [3:0] f);
    flags_valid = 1'b1;
    flags       = f;
  endtask

  // Queue the expectation for the current inputs, let the monitor observe
  // this cycle, then advance past the next rising edge.
  task automatic chk(input string n, input logic [31:0] v0, input logic [31:0] v1,
                     input logic [31:0] v2, input logic [2:0] haz, input logic hold);
    exp_t x;
    x.v0 = v0; x.v1 = v1; x.v2 = v2; x.haz = haz; x.hold = hold;
    exp_q.push_back(x);
    name_q.push_back(n);
    chk_vld = 1'b1;
    @(posedge clock);
    #1;
    chk_vld = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    n_tests  = 0;
    n_fail   = 0;
    chk_vld  = 1'b0;
    reset_n  = 1'b0;
    pc       = 32'h100;
    rd(0, 0, 0);
    idle();
    repeat (3) tick();
    reset_n = 1'b1;

    idle(); rd(0, 5, 30);                chk("reset_read",  32'h0, 32'h0, 32'h100, 3'b000, 1'b0);
    idle(); wr(5, 32'hDEADBEEF); rd(5, 0, 30);
                                         chk("wr_bypass",   32'hDEADBEEF, 32'h0, 32'h100, 3'b000, 1'b0);
    idle(); rd(5, 0, 30);                chk("wr_stored",   32'hDEADBEEF, 32'h0, 32'h100, 3'b000, 1'b0);
    idle(); wr(0, 32'h1234); rd(0, 5, 30);
                                         chk("r0_write",    32'h0, 32'hDEADBEEF, 32'h100, 3'b000, 1'b0);
    idle(); wr(30, 32'h9999); rd(30, 0, 5);
                                         chk("pc_write",    32'h100, 32'h0, 32'hDEADBEEF, 3'b000, 1'b0);
    idle(); rd(0, 30, 5);                chk("r0_pc_kept",  32'h0, 32'h100, 32'hDEADBEEF, 3'b000, 1'b0);

    idle(); iss(7); rd(7, 5, 0);         chk("issue_r7",    32'h0, 32'hDEADBEEF, 32'h0, 3'b000, 1'b0);
    idle(); rd(7, 5, 0);                 chk("raw_hazard",  32'h0, 32'hDEADBEEF, 32'h0, 3'b001, 1'b0);
    idle(); wr(7, 32'h55);               chk("commit_byp",  32'h55, 32'hDEADBEEF, 32'h0, 3'b000, 1'b0);
    idle();                              chk("pend_clear",  32'h55, 32'hDEADBEEF, 32'h0, 3'b000, 1'b0);
    idle(); iss(7); tick();
    idle(); iss(7);                      chk("waw_hold",    32'h55, 32'hDEADBEEF, 32'h0, 3'b001, 1'b1);
    idle(); iss(7); wr(7, 32'h66);       chk("iss_commit",  32'h66, 32'hDEADBEEF, 32'h0, 3'b000, 1'b0);
    idle();                              chk("set_wins",    32'h66, 32'hDEADBEEF, 32'h0, 3'b001, 1'b0);
    idle(); wr(7, 32'h77); tick();

    idle(); wr(31, 32'hFFFFFFF0); tick();
    idle(); fl(4'hA); rd(31, 7, 0);      chk("flags_byp",   32'hFFFFFFFA, 32'h77, 32'h0, 3'b000, 1'b0);
    idle();                              chk("flags_store", 32'hFFFFFFFA, 32'h77, 32'h0, 3'b000, 1'b0);
    idle(); wr(31, 32'h12345670); fl(4'h3);
                                         chk("flags_merge", 32'h12345673, 32'h77, 32'h0, 3'b000, 1'b0);
    idle();                              chk("merge_store", 32'h12345673, 32'h77, 32'h0, 3'b000, 1'b0);

    idle(); iss(3); tick();
    idle(); iss(4); tick();
    idle(); rd(3, 4, 9);                 chk("two_pending", 32'h0, 32'h0, 32'h0, 3'b011, 1'b0);
    idle(); flush = 1'b1; iss(9);        chk("flush_cycle", 32'h0, 32'h0, 32'h0, 3'b011, 1'b0);
    idle();                              chk("flushed",     32'h0, 32'h0, 32'h0, 3'b000, 1'b0);

    idle(); iss(9); tick();
    idle(); iss(9); rd(9, 5, 7);         chk("pre_reset",   32'h0, 32'hDEADBEEF, 32'h77, 3'b001, 1'b1);
    idle(); iss(9); reset_n = 1'b0;      chk("async_reset", 32'h0, 32'h0, 32'h0, 3'b000, 1'b0);
    reset_n = 1'b1;
    idle(); rd(31, 30, 9);               chk("post_reset",  32'h0, 32'h100, 32'h0, 3'b000, 1'b0);

    tick();
    n_tests++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL drain: %0d expectations left, expected 0", exp_q.size());
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/register_file_scoreboard.md
Name: register_file_scoreboard

Overview:
- Parametrised architectural register file for the Flurbie pipeline, generalising the fixed 4-entry register file type.
- Serves NREAD combinational read ports to the read stage, with write-to-read bypass from the write stage.
- Keeps a per-register pending-write scoreboard that flags RAW hazards and holds WAW issues.
- r0 is hardwired to zero, the PC slot returns the supplied pc, and the Flags slot takes a dedicated 4-bit flags update.

Parameters:
NR, 32, number of architectural registers; power of two, 4..32 (indices are fixed 5-bit). PC = NR-2, Flags = NR-1.
NREAD, 3, number of read ports (left, right, address).
W, 32, register width in bits.

Ports:
clock  in  1  rising-edge clock
reset_n  in  1  asynchronous active-low reset
pc  in  W  value returned for reads of index PC
rd_index  in  NREAD x 5  read port register indices
rd_value  out  NREAD x W  read data, combinational
rd_hazard  out  NREAD  source register has a pending write not satisfied by this cycle's bypass
issue_valid  in  1  decode issues an instruction that writes issue_register
issue_register  in  5  destination register of the issued instruction
issue_hold  out  1  issue refused (WAW on pending register); decode must retry
flush  in  1  pipeline flush; clears all pending bits
wr_valid  in  1  write stage commits wr_value to wr_register
wr_register  in  5  commit destination register
wr_value  in  W  commit data
flags_valid  in  1  write stage updates the flags
flags  in  4  new N/Z/C/V-style flags (bits 3:0 of the Flags register)

Behaviour:
- Reset (reset_n low, asynchronous): all registers = 0, all pending bits = 0. Outputs are combinational from this state: rd_value = 0 except reads of PC, which return pc; rd_hazard = 0; issue_hold = 0.
- Index legality: an index >= NR reads 0, never hazards, and its writes and issues are ignored (issue_hold = 0).
- Read mux, per port, combinational, in priority order:
  - index 0 -> 0;
  - index PC -> pc input;
  - wr_valid && wr_register == index -> wr_value (bypass);
  - otherwise the stored value.
- Flags read bypass: if flags_valid, bits 3:0 come from flags, overriding wr_value.
- Writes, at the rising edge of clock:
  - wr_valid writes wr_value to wr_register, except r0 and PC, which are never written.
  - flags_valid writes Flags[3:0] = flags. Upper Flags bits are changed only by a wr_valid write to Flags.
  - Simultaneous wr_valid to Flags and flags_valid: Flags <= {wr_value[W-1:4], flags}.
- Scoreboard, pending[NR] with bits 0 and PC always 0:
  - rd_hazard[i] = pending[rd_index[i]] && !(wr_valid && wr_register == rd_index[i]).
  - issue_hold = issue_valid && pending[issue_register] && !(wr_valid && wr_register == issue_register) && !flush.
  - The issue is accepted when issue_valid && !issue_hold && !flush && issue_register is not 0, PC or >= NR. On acceptance, pending[issue_register] is set at the edge.
  - wr_valid clears pending[wr_register] at the edge.
  - Same register accepted and committed in the same cycle: set wins, so the bit stays 1.
  - flush clears every pending bit at the edge and suppresses a same-cycle issue.
  - flags_valid does not touch pending.
- Latency:
  - Reads are 0 cycles.
  - A write is visible the same cycle via bypass and stored from the next cycle.
  - A pending bit is visible the cycle after issue.
- Reset mid-operation clears all state immediately, regardless of clock.

Test Plan:
- Reset, then read r0, r5, PC with pc=0x100 -> rd_value = 0, 0, 0x100; rd_hazard = 0.
- wr_valid r5=0xDEADBEEF, read r5 same cycle -> bypass 0xDEADBEEF; next cycle, no write -> stored 0xDEADBEEF. Write 0x1234 to r0 -> r0 still reads 0.
- issue r7; next cycle read r7 -> rd_hazard = 1. Commit r7=0x55 -> same cycle hazard = 0 and value 0x55; next cycle pending cleared.
- r7 pending, issue r7 again -> issue_hold = 1. Issue r7 in the same cycle as commit r7 -> accepted, pending stays 1.
- Flags=0xFFFFFFF0, flags_valid with 4'hA -> reads 0xFFFFFFFA. Simultaneous wr Flags=0x12345670 with flags 4'h3 -> 0x12345673.
- Issue r3, r4, then flush with issue r9 -> all pending 0, r9 not pending. Assert reset_n low mid-run -> all registers read 0 immediately.
